// File: rtl/ch9329_pkg.sv
// Shared constants for the CH9329 serial link (transmitter and receiver).
// Holds the frame header bytes, the keyboard-general command, the frame
// length, the transmitter state encoding and the frame byte selector.
package ch9329_pkg;

  localparam logic [7:0] CH_HDR0        = 8'h57;
  localparam logic [7:0] CH_HDR1        = 8'hAB;
  localparam logic [7:0] CH_ADDR        = 8'h00;
  localparam logic [7:0] CMD_KB_GENERAL = 8'h02;
  localparam logic [7:0] LEN_KB         = 8'h08;
  localparam int         FRAME_BYTES    = 14;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD   = S_LOAD,
    ST_SEND   = S_SEND,
    ST_FINISH = S_FINISH
  } tx_state_e;

  // Byte idx of a keyboard-general frame. Index 13 returns the running sum,
  // which by then holds all 13 preceding bytes.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [7:0]  mod,
                                            input logic [47:0] keys,
                                            input logic [7:0]  sum);
    logic [7:0] b;
    case (idx)
      4'd0:    b = CH_HDR0;
      4'd1:    b = CH_HDR1;
      4'd2:    b = CH_ADDR;
      4'd3:    b = CMD_KB_GENERAL;
      4'd4:    b = LEN_KB;
      4'd5:    b = mod;
      4'd6:    b = 8'h00;
      4'd7:    b = keys[7:0];
      4'd8:    b = keys[15:8];
      4'd9:    b = keys[23:16];
      4'd10:   b = keys[31:24];
      4'd11:   b = keys[39:32];
      4'd12:   b = keys[47:40];
      default: b = sum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ch9329_hid_transmitter_uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 UART sender, LSB first.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        accept data when not busy
//   data[7:0]   byte to send
//   tx          serial line, idle high (registered)
//   byte_busy   high while a byte is on the line
//   byte_done   high in the last cycle of the stop bit (combinational), so a
//               caller can load the next byte with at most one idle cycle
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1259
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_busy,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;   // 0 start, 1..8 data, 9 stop
  logic [9:0]    shreg;     // {stop, data, start}; shreg[0] is on the line
  logic          bit_end;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign byte_done = byte_busy && bit_end && (bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      byte_busy <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
    end else if (!byte_busy) begin
      if (load) begin
        shreg     <= {1'b1, data, 1'b0};
        tx        <= 1'b0;
        byte_busy <= 1'b1;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        byte_busy <= 1'b0;
        tx        <= 1'b1;
        bit_cnt   <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {1'b1, shreg[9:1]};
        tx      <= shreg[1];
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ch9329_hid_transmitter.sv
// ch9329_hid_transmitter: builds and sends a CH9329 keyboard-general frame
// (57 AB 00 02 08 mod 00 k0..k5 SUM) over 8N1 UART.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle request, honoured only when idle
//   modifier     HID modifier byte
//   keycodes     six HID usages, key0 = [7:0]
//   busy         high from accept until the frame ends
//   done         one-cycle pulse as the final stop bit completes
//   tx           UART line to CH9329 RX, idle high
module ch9329_hid_transmitter
  import ch9329_pkg::*;
#(
  parameter int SYS_FREQ = 12_090_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  modifier,
  input  logic [47:0] keycodes,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int         CLKS_PER_BIT = SYS_FREQ / BAUD;
  localparam logic [3:0] LAST_IDX     = 4'(FRAME_BYTES - 1);

  tx_state_e   state;
  logic [3:0]  idx;
  logic [7:0]  mod_q;
  logic [47:0] keys_q;
  logic [7:0]  sum;
  logic [7:0]  cur_byte;
  logic        load;
  logic        byte_busy;
  logic        byte_done;

  assign cur_byte = frame_byte(idx, mod_q, keys_q, sum);
  // Load straight out of LOAD so the next start bit follows the previous
  // stop bit with a single idle cycle.
  assign load = (state == ST_LOAD) && !byte_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      mod_q  <= '0;
      keys_q <= '0;
      sum    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mod_q  <= modifier;
            keys_q <= keycodes;
            idx    <= '0;
            sum    <= '0;
            busy   <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!byte_busy) begin
            if (idx != LAST_IDX) sum <= sum + cur_byte;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (byte_done) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FINISH;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_LOAD;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (cur_byte),
    .tx        (tx),
    .byte_busy (byte_busy),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_ch9329_hid_transmitter.sv
module tb_ch9329_hid_transmitter;

  localparam int C = 16;   // clocks per bit: SYS_FREQ/BAUD = 160/10

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  modifier = '0;
  logic [47:0] keycodes = '0;
  logic        busy, done, tx;

  ch9329_hid_transmitter #(.SYS_FREQ(160), .BAUD(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modifier(modifier),
    .keycodes(keycodes), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mod;
    logic [47:0] keys;
    logic [7:0]  sum;
  } vec_t;

  vec_t       vecs [7];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         done_busy_bad = 0;
  bit         idle_watch = 0;
  int         idle_bad = 0;
  bit         rec_en = 0;
  int         runs [$];
  int         run_len = 0;
  logic       prev_tx = 1'b1;
  logic [7:0] got [14];
  bit         rx_to;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_bad++;
    end
    if (idle_watch && (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)) idle_bad++;
    if (!rec_en) begin
      run_len = 0;
      prev_tx = tx;
    end else if (tx !== prev_tx) begin
      runs.push_back(run_len);
      run_len = 1;
      prev_tx = tx;
    end else begin
      run_len++;
    end
  end

  // Pulse start, then scramble the inputs; checks busy and start-bit latency.
  task automatic send_start(input logic [7:0] m, input logic [47:0] k);
    int lat;
    @(negedge clk);
    modifier = m; keycodes = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modifier = ~m; keycodes = ~k;
    chk("busy_after_accept", busy, 1'b1);
    lat = 1;
    while (tx !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat > 2) begin
      errors++;
      $display("FAIL start_latency: got %0d cycles required <= 2", lat);
    end
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit to);
    int n;
    n = 0; to = 0; b = '0;
    while (tx !== 1'b0 && n < 30 * C) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      to = 1;
      return;
    end
    repeat (C / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
    repeat (C) @(negedge clk);
    chk("stop_bit", tx, 1'b1);
  endtask

  task automatic rx_frame();
    rx_to = 0;
    for (int i = 0; i < 14; i++) begin
      rx_byte(got[i], rx_to);
      if (rx_to) begin
        chk("rx_timeout", 1'b1, 1'b0);
        return;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] m,
                             input logic [47:0] k, input logic [7:0] s);
    logic [7:0] exp [14];
    exp[0] = 8'h57; exp[1] = 8'hAB; exp[2] = 8'h00; exp[3] = 8'h02;
    exp[4] = 8'h08; exp[5] = m; exp[6] = 8'h00; exp[13] = s;
    for (int i = 0; i < 6; i++) exp[7 + i] = k[8 * i +: 8];
    for (int i = 0; i < 14; i++)
      chk($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
    repeat (C) @(negedge clk);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    done_cnt = 0;
    send_start(v.mod, v.keys);
    rx_frame();
    check_frame(name, v.mod, v.keys, v.sum);
  endtask

  initial begin
    vecs[0] = '{8'h00, 48'h0000_0000_0004, 8'h10};
    vecs[1] = '{8'h00, 48'h0000_0000_0000, 8'h0C};
    vecs[2] = '{8'hFF, 48'hFFFF_FFFF_FFFF, 8'h05};
    vecs[3] = '{8'h02, 48'h0000_0000_0B04, 8'h1D};
    vecs[4] = '{8'h81, 48'h2827_2625_2423, 8'h6E};
    vecs[5] = '{8'h00, 48'h0000_0000_0404, 8'h14};
    vecs[6] = '{8'h02, 48'h0000_0000_0B04, 8'h1D};

    // Reset state
    #12;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch = 1;
    repeat (10000) @(negedge clk);
    idle_watch = 0;
    chk("idle_10k", idle_bad, 0);

    // First frame also records line run lengths for bit timing
    done_cnt = 0;
    rec_en = 1;
    send_start(vecs[0].mod, vecs[0].keys);
    rx_frame();
    rec_en = 0;
    check_frame("v0", vecs[0].mod, vecs[0].keys, vecs[0].sum);
    // 0x57 LSB first: start 0 | 111 | 0 | 1 | 0 | 1 | 0 | stop 1 (+gap)
    if (runs.size() >= 9) begin
      chk("t_start_bit", runs[1], C);
      chk("t_bits0_2", runs[2], 3 * C);
      for (int i = 3; i < 8; i++) chk($sformatf("t_bit%0d", i), runs[i], C);
      checks++;
      if (runs[8] < C || runs[8] > C + 1) begin
        errors++;
        $display("FAIL t_stop_gap: got %0d required %0d..%0d", runs[8], C, C + 1);
      end
    end else begin
      chk("t_runs_count", runs.size(), 9);
    end

    for (int v = 1; v < 6; v++) run_vec($sformatf("v%0d", v), vecs[v]);

    // start hammered mid-frame with changing inputs: one frame, latched values
    done_cnt = 0;
    send_start(vecs[6].mod, vecs[6].keys);
    fork
      rx_frame();
      begin
        repeat (12) begin
          repeat (97) @(negedge clk);
          modifier = 8'($urandom);
          keycodes = {16'($urandom), 32'($urandom)};
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    check_frame("spam", vecs[6].mod, vecs[6].keys, vecs[6].sum);
    idle_bad = 0;
    idle_watch = 1;
    repeat (400) @(negedge clk);
    idle_watch = 0;
    chk("spam_no_second_frame", idle_bad, 0);

    // Asynchronous reset during byte 6
    send_start(vecs[2].mod, vecs[2].keys);
    repeat (1040) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_vec("after_reset", vecs[4]);

    chk("done_with_busy_low", done_busy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
